// File: rtl/dcache_port_ctrl.sv
// rtl/dcache_port_ctrl.sv - D$ port controller: one-entry load register with tag tracking, plus a store buffer FIFO.
module dcache_port_ctrl #(
  parameter int LQ_INDEX_WIDTH = 3,
  parameter int SB_DEPTH       = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ld_req_valid,
  output logic                      ld_req_ready,
  input  logic [LQ_INDEX_WIDTH-1:0] ld_req_LQ_index,
  input  logic [13:0]               ld_req_addr,
  output logic                      dcache_read_req_valid,
  output logic [LQ_INDEX_WIDTH-1:0] dcache_read_req_LQ_index,
  output logic [13:0]               dcache_read_req_addr,
  input  logic                      dcache_read_req_blocked,
  input  logic                      dcache_read_resp_valid,
  input  logic [LQ_INDEX_WIDTH-1:0] dcache_read_resp_LQ_index,
  input  logic [31:0]               dcache_read_resp_data,
  output logic                      ld_resp_valid,
  output logic [LQ_INDEX_WIDTH-1:0] ld_resp_LQ_index,
  output logic [31:0]               ld_resp_data,
  input  logic                      st_req_valid,
  output logic                      st_req_ready,
  input  logic [13:0]               st_req_addr,
  input  logic [31:0]               st_req_data,
  output logic                      dcache_write_req_valid,
  output logic [13:0]               dcache_write_req_addr,
  output logic [31:0]               dcache_write_req_data,
  input  logic                      dcache_write_req_blocked,
  output logic                      sb_empty,
  output logic                      port_error
);

  localparam int LQ_N  = 1 << LQ_INDEX_WIDTH;
  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);

  // Load path
  logic                      ld_occ;
  logic [LQ_INDEX_WIDTH-1:0] ld_tag;
  logic [13:0]               ld_addr;
  logic [LQ_N-1:0]           outstanding;
  logic [LQ_N-1:0]           outstanding_next;
  logic                      ld_drain;
  logic                      ld_accept;

  assign ld_drain  = ld_occ && !dcache_read_req_blocked;
  // A tag may not be re-issued while it is still in the register or awaiting data.
  assign ld_req_ready = (!ld_occ || ld_drain)
                      && !outstanding[ld_req_LQ_index]
                      && !(ld_occ && (ld_tag == ld_req_LQ_index));
  assign ld_accept = ld_req_valid && ld_req_ready;

  assign dcache_read_req_valid    = ld_occ;
  assign dcache_read_req_LQ_index = ld_tag;
  assign dcache_read_req_addr     = ld_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ld_occ  <= 1'b0;
      ld_tag  <= '0;
      ld_addr <= '0;
    end else if (ld_accept) begin
      ld_occ  <= 1'b1;
      ld_tag  <= ld_req_LQ_index;
      ld_addr <= ld_req_addr;
    end else if (ld_drain) begin
      ld_occ  <= 1'b0;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    if (dcache_read_resp_valid) outstanding_next[dcache_read_resp_LQ_index] = 1'b0;
    if (ld_drain)               outstanding_next[ld_tag] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      outstanding      <= '0;
      ld_resp_valid    <= 1'b0;
      ld_resp_LQ_index <= '0;
      ld_resp_data     <= '0;
      port_error       <= 1'b0;
    end else begin
      outstanding      <= outstanding_next;
      ld_resp_valid    <= dcache_read_resp_valid;
      ld_resp_LQ_index <= dcache_read_resp_LQ_index;
      ld_resp_data     <= dcache_read_resp_data;
      if (dcache_read_resp_valid && !outstanding[dcache_read_resp_LQ_index])
        port_error <= 1'b1;
    end
  end

  // Store buffer; pointers wrap naturally since SB_DEPTH is a power of 2
  logic [13:0]      sb_addr [SB_DEPTH];
  logic [31:0]      sb_data [SB_DEPTH];
  logic [PTR_W-1:0] sb_wr_ptr;
  logic [PTR_W-1:0] sb_rd_ptr;
  logic [CNT_W-1:0] sb_count;
  logic             sb_push;
  logic             sb_pop;

  assign st_req_ready           = sb_count < SB_FULL;
  assign sb_push                = st_req_valid && st_req_ready;
  assign dcache_write_req_valid = sb_count != '0;
  assign sb_pop                 = dcache_write_req_valid && !dcache_write_req_blocked;
  assign dcache_write_req_addr  = sb_addr[sb_rd_ptr];
  assign dcache_write_req_data  = sb_data[sb_rd_ptr];
  assign sb_empty               = sb_count == '0;

  always_ff @(posedge CLK) begin
    if (sb_push) begin
      sb_addr[sb_wr_ptr] <= st_req_addr;
      sb_data[sb_wr_ptr] <= st_req_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sb_wr_ptr <= '0;
      sb_rd_ptr <= '0;
      sb_count  <= '0;
    end else begin
      if (sb_push) sb_wr_ptr <= sb_wr_ptr + PTR_W'(1);
      if (sb_pop)  sb_rd_ptr <= sb_rd_ptr + PTR_W'(1);
      case ({sb_push, sb_pop})
        2'b10:   sb_count <= sb_count + CNT_W'(1);
        2'b01:   sb_count <= sb_count - CNT_W'(1);
        default: sb_count <= sb_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// tb/tb_dcache_port_ctrl.sv - Table-driven and directed checks for dcache_port_ctrl.
module tb_dcache_port_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [2:0]  ld_req_LQ_index;
  logic [13:0] ld_req_addr;
  logic        dcache_read_req_valid;
  logic [2:0]  dcache_read_req_LQ_index;
  logic [13:0] dcache_read_req_addr;
  logic        dcache_read_req_blocked;
  logic        dcache_read_resp_valid;
  logic [2:0]  dcache_read_resp_LQ_index;
  logic [31:0] dcache_read_resp_data;
  logic        ld_resp_valid;
  logic [2:0]  ld_resp_LQ_index;
  logic [31:0] ld_resp_data;
  logic        st_req_valid;
  logic        st_req_ready;
  logic [13:0] st_req_addr;
  logic [31:0] st_req_data;
  logic        dcache_write_req_valid;
  logic [13:0] dcache_write_req_addr;
  logic [31:0] dcache_write_req_data;
  logic        dcache_write_req_blocked;
  logic        sb_empty;
  logic        port_error;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dcache_port_ctrl #(.LQ_INDEX_WIDTH(3), .SB_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_LQ_index(ld_req_LQ_index), .ld_req_addr(ld_req_addr),
    .dcache_read_req_valid(dcache_read_req_valid),
    .dcache_read_req_LQ_index(dcache_read_req_LQ_index),
    .dcache_read_req_addr(dcache_read_req_addr),
    .dcache_read_req_blocked(dcache_read_req_blocked),
    .dcache_read_resp_valid(dcache_read_resp_valid),
    .dcache_read_resp_LQ_index(dcache_read_resp_LQ_index),
    .dcache_read_resp_data(dcache_read_resp_data),
    .ld_resp_valid(ld_resp_valid), .ld_resp_LQ_index(ld_resp_LQ_index),
    .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .dcache_write_req_valid(dcache_write_req_valid),
    .dcache_write_req_addr(dcache_write_req_addr),
    .dcache_write_req_data(dcache_write_req_data),
    .dcache_write_req_blocked(dcache_write_req_blocked),
    .sb_empty(sb_empty), .port_error(port_error)
  );

  typedef struct {
    logic ldv; logic [2:0] ltag; logic [13:0] laddr; logic rblk;
    logic rspv; logic [2:0] rtag; logic [31:0] rdata;
    logic stv; logic [13:0] saddr; logic wblk;
    logic e_ldrdy; logic e_rdv; logic [2:0] e_rdtag; logic [13:0] e_rdaddr;
    logic e_strdy; logic e_wrv; logic [13:0] e_wraddr; logic e_sbe;
    logic e_lrv; logic [2:0] e_lrtag; logic [31:0] e_lrdata; logic e_perr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ld_req_valid = 0; ld_req_LQ_index = 0; ld_req_addr = 0;
    dcache_read_req_blocked = 0;
    dcache_read_resp_valid = 0; dcache_read_resp_LQ_index = 0; dcache_read_resp_data = 0;
    st_req_valid = 0; st_req_addr = 0; st_req_data = 0;
    dcache_write_req_blocked = 0;
  endtask

  function automatic logic [31:0] sdat(input logic [13:0] a);
    return 32'hA000_0000 | {18'h0, a};
  endfunction

  task automatic store(input logic [13:0] a, input logic blk);
    st_req_valid = 1; st_req_addr = a; st_req_data = sdat(a);
    dcache_write_req_blocked = blk;
  endtask

  initial begin
    idle();
    RST = 1;
    repeat (2) @(posedge CLK);
    RST = 0;

    // ldv ltag laddr rblk | rspv rtag rdata | stv saddr wblk | ldrdy rdv rdtag rdaddr | strdy wrv wraddr sbe | lrv lrtag lrdata perr
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{1,2,14'h040,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,1,2,14'h040, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 1,2,32'hDEADBEEF, 0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 1,2,32'hDEADBEEF,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h100,1, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h101,1, 1,0,0,14'h000, 1,1,14'h100,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h102,1, 1,0,0,14'h000, 1,1,14'h100,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h103,1, 1,0,0,14'h000, 1,1,14'h100,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h104,1, 1,0,0,14'h000, 0,1,14'h100,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h105,0, 1,0,0,14'h000, 0,1,14'h100,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,1,14'h101,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h106,0, 1,0,0,14'h000, 1,1,14'h102,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,1,14'h103,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        1,14'h107,0, 1,0,0,14'h000, 1,1,14'h106,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,1,14'h107,0, 0,0,32'h0,0});
    vecs.push_back('{0,0,14'h000,0, 0,0,32'h0,        0,14'h000,0, 1,0,0,14'h000, 1,0,14'h000,1, 0,0,32'h0,0});

    foreach (vecs[i]) begin
      @(negedge CLK);
      ld_req_valid = vecs[i].ldv; ld_req_LQ_index = vecs[i].ltag; ld_req_addr = vecs[i].laddr;
      dcache_read_req_blocked = vecs[i].rblk;
      dcache_read_resp_valid = vecs[i].rspv; dcache_read_resp_LQ_index = vecs[i].rtag;
      dcache_read_resp_data = vecs[i].rdata;
      st_req_valid = vecs[i].stv; st_req_addr = vecs[i].saddr; st_req_data = sdat(vecs[i].saddr);
      dcache_write_req_blocked = vecs[i].wblk;
      #1;
      chk($sformatf("v%0d_ld_req_ready", i), 32'(ld_req_ready), 32'(vecs[i].e_ldrdy));
      chk($sformatf("v%0d_rd_valid", i), 32'(dcache_read_req_valid), 32'(vecs[i].e_rdv));
      if (vecs[i].e_rdv) begin
        chk($sformatf("v%0d_rd_tag", i), 32'(dcache_read_req_LQ_index), 32'(vecs[i].e_rdtag));
        chk($sformatf("v%0d_rd_addr", i), 32'(dcache_read_req_addr), 32'(vecs[i].e_rdaddr));
      end
      chk($sformatf("v%0d_st_req_ready", i), 32'(st_req_ready), 32'(vecs[i].e_strdy));
      chk($sformatf("v%0d_wr_valid", i), 32'(dcache_write_req_valid), 32'(vecs[i].e_wrv));
      if (vecs[i].e_wrv) begin
        chk($sformatf("v%0d_wr_addr", i), 32'(dcache_write_req_addr), 32'(vecs[i].e_wraddr));
        chk($sformatf("v%0d_wr_data", i), dcache_write_req_data, sdat(vecs[i].e_wraddr));
      end
      chk($sformatf("v%0d_sb_empty", i), 32'(sb_empty), 32'(vecs[i].e_sbe));
      chk($sformatf("v%0d_ld_resp_valid", i), 32'(ld_resp_valid), 32'(vecs[i].e_lrv));
      if (vecs[i].e_lrv) begin
        chk($sformatf("v%0d_ld_resp_tag", i), 32'(ld_resp_LQ_index), 32'(vecs[i].e_lrtag));
        chk($sformatf("v%0d_ld_resp_data", i), ld_resp_data, vecs[i].e_lrdata);
      end
      chk($sformatf("v%0d_port_error", i), 32'(port_error), 32'(vecs[i].e_perr));
    end

    // Blocked read holds for 3 cycles, then a same-tag reload waits for the response
    @(negedge CLK); idle();
    ld_req_valid = 1; ld_req_LQ_index = 5; ld_req_addr = 14'h055; dcache_read_req_blocked = 1;
    #1 chk("blk_accept_ready", 32'(ld_req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); idle();
      ld_req_valid = 1; ld_req_LQ_index = 5; ld_req_addr = 14'h099; dcache_read_req_blocked = 1;
      #1;
      chk($sformatf("blk%0d_rd_valid", k), 32'(dcache_read_req_valid), 32'd1);
      chk($sformatf("blk%0d_rd_tag", k), 32'(dcache_read_req_LQ_index), 32'd5);
      chk($sformatf("blk%0d_rd_addr", k), 32'(dcache_read_req_addr), 32'h055);
      chk($sformatf("blk%0d_ld_ready", k), 32'(ld_req_ready), 32'd0);
    end
    @(negedge CLK); idle();
    ld_req_valid = 1; ld_req_LQ_index = 5; ld_req_addr = 14'h099;
    #1;
    chk("issue_rd_valid", 32'(dcache_read_req_valid), 32'd1);
    chk("issue_same_tag_ready", 32'(ld_req_ready), 32'd0);
    @(negedge CLK); idle();
    ld_req_valid = 1; ld_req_LQ_index = 5;
    #1;
    chk("after_issue_rd_valid", 32'(dcache_read_req_valid), 32'd0);
    chk("outstanding_tag5_ready", 32'(ld_req_ready), 32'd0);
    @(negedge CLK); idle();
    ld_req_LQ_index = 3;
    #1 chk("other_tag3_ready", 32'(ld_req_ready), 32'd1);
    @(negedge CLK); idle();
    ld_req_LQ_index = 5;
    dcache_read_resp_valid = 1; dcache_read_resp_LQ_index = 5; dcache_read_resp_data = 32'h1234_5678;
    #1 chk("resp_cycle_tag5_ready", 32'(ld_req_ready), 32'd0);
    @(negedge CLK); idle();
    ld_req_LQ_index = 5;
    #1;
    chk("post_resp_tag5_ready", 32'(ld_req_ready), 32'd1);
    chk("post_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("post_resp_tag", 32'(ld_resp_LQ_index), 32'd5);
    chk("post_resp_data", ld_resp_data, 32'h1234_5678);
    chk("post_resp_no_error", 32'(port_error), 32'd0);

    // Unsolicited response sets a sticky error
    @(negedge CLK); idle();
    dcache_read_resp_valid = 1; dcache_read_resp_LQ_index = 7; dcache_read_resp_data = 32'h77;
    #1 chk("spur_before_error", 32'(port_error), 32'd0);
    @(negedge CLK); idle();
    #1;
    chk("spur_error_set", 32'(port_error), 32'd1);
    chk("spur_forwarded_tag", 32'(ld_resp_LQ_index), 32'd7);
    chk("spur_forwarded_valid", 32'(ld_resp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); idle();
      #1 chk($sformatf("spur_sticky%0d", k), 32'(port_error), 32'd1);
    end

    // Reset with a tag outstanding and stores buffered
    @(negedge CLK); idle();
    ld_req_valid = 1; ld_req_LQ_index = 1; ld_req_addr = 14'h011;
    #1 chk("rst_seq_ld_ready", 32'(ld_req_ready), 32'd1);
    @(negedge CLK); idle();
    #1 chk("rst_seq_rd_valid", 32'(dcache_read_req_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); idle();
      store(14'h200 + 14'(k), 1'b1);
    end
    @(negedge CLK); idle();
    dcache_write_req_blocked = 1; ld_req_LQ_index = 1;
    #1;
    chk("pre_rst_tag1_ready", 32'(ld_req_ready), 32'd0);
    chk("pre_rst_wr_valid", 32'(dcache_write_req_valid), 32'd1);
    chk("pre_rst_wr_addr", 32'(dcache_write_req_addr), 32'h200);
    RST = 1;
    @(negedge CLK); idle();
    RST = 0; ld_req_LQ_index = 1;
    #1;
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_wr_valid", 32'(dcache_write_req_valid), 32'd0);
    chk("rst_rd_valid", 32'(dcache_read_req_valid), 32'd0);
    chk("rst_mask_tag1_ready", 32'(ld_req_ready), 32'd1);
    chk("rst_st_ready", 32'(st_req_ready), 32'd1);
    chk("rst_port_error", 32'(port_error), 32'd0);
    chk("rst_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
    chk("rst_ld_resp_data", ld_resp_data, 32'h0);
    @(negedge CLK); idle();
    dcache_read_resp_valid = 1; dcache_read_resp_LQ_index = 1; dcache_read_resp_data = 32'h11;
    @(negedge CLK); idle();
    #1 chk("late_resp_error", 32'(port_error), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
